// File: rtl/psum_pkg.sv
// Shared definitions for the psum read-modify-write engine.
//  - state_t     : FSM state encoding of psum_accum_ctrl
//  - PSENB_BIT   : bit of the config register that hands the BRAM bus to the PS
//  - BYTE_SHIFT  : word index to byte address shift (32-bit words)
//  - sat_add     : signed add with optional clamp to a given word width
package psum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_CLR  = 3'd4
  } state_t;

  localparam int PSENB_BIT  = 2;
  localparam int BYTE_SHIFT = 2;

  // Operands arrive sign-extended to 64 bits, so the raw sum cannot overflow
  // for any width up to 62. The caller truncates the result to its width;
  // with saturate=0 that truncation is the modulo wrap.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        width,
    input logic               saturate
  );
    logic signed [63:0] sum_v;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum_v = a + b;
    max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 32'd1));
    if (saturate && (sum_v > max_v)) begin
      sat_add = max_v;
    end else if (saturate && (sum_v < min_v)) begin
      sat_add = min_v;
    end else begin
      sat_add = sum_v;
    end
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed adder for psum words, clamping to the signed range
// when SATURATE is non-zero and wrapping otherwise.
// Ports:
//   a, b : DATA_WIDTH-bit two's complement operands
//   sum  : DATA_WIDTH-bit result
module psum_sat_add
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SATURATE   = 1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  assign sum = DATA_WIDTH'(sat_add(64'(signed'(a)), 64'(signed'(b)),
                                   DATA_WIDTH, SATURATE != 0));

endmodule

// File: rtl/psum_accum_ctrl.sv
// Read-modify-write engine driving the PL port of the psum BRAM mux.
// Accepted partial sums are either written directly (first pass) or read,
// added to the stored word and written back. A clear sweep zeroes DEPTH
// words. Whenever the PS owns the bus (conf bit PSENB_BIT) the engine stays
// idle, and any operation in flight is aborted with a sticky error flag.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_conf_ctrl         : config register, PSENB_BIT = PS owns the bus
//   i_psum_vld/idx/data/first, o_psum_rdy : partial sum handshake
//   i_clr_start, o_clr_done               : clear sweep start / done pulse
//   o_busy, o_err, o_wr_cnt               : status and completed-write count
//   mem_addr/idat/odat/wren/enb/rst       : BRAM port (byte address)
module psum_accum_ctrl
  import psum_pkg::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter int              NUM_BYTE   = 4,
  parameter int              REG_WIDTH  = 32,
  parameter int              IDX_WIDTH  = 10,
  parameter int              DEPTH      = 1024,
  parameter logic [31:0]     BASE_ADDR  = 32'h0,
  parameter int              RD_LAT     = 2,
  parameter int              SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic                  i_psum_vld,
  input  logic [IDX_WIDTH-1:0]  i_psum_idx,
  input  logic [DATA_WIDTH-1:0] i_psum_data,
  input  logic                  i_psum_first,
  output logic                  o_psum_rdy,
  input  logic                  i_clr_start,
  output logic                  o_clr_done,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [31:0]           o_wr_cnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [NUM_BYTE-1:0]   mem_wren,
  output logic                  mem_enb,
  output logic                  mem_rst
);

  localparam int                   WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LOAD = WAIT_W'(RD_LAT - 1);
  localparam logic [WAIT_W-1:0]    WAIT_ONE  = WAIT_W'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(DEPTH - 1);

  state_t                  state_r, state_s;
  logic [IDX_WIDTH-1:0]    idx_r, idx_s;
  logic [DATA_WIDTH-1:0]   data_r, data_s;
  logic [WAIT_W-1:0]       wait_r, wait_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [DATA_WIDTH-1:0]   idat_s;
  logic                    enb_s, wr_s, done_s, err_s, cnt_inc_s;
  logic [DATA_WIDTH-1:0]   sum_s;
  logic                    psenb_s;
  logic                    unused_conf_s;

  assign psenb_s       = i_conf_ctrl[PSENB_BIT];
  assign unused_conf_s = ^{i_conf_ctrl[REG_WIDTH-1:PSENB_BIT+1], i_conf_ctrl[PSENB_BIT-1:0]};
  assign mem_rst       = 1'b0;

  // Ready must be combinational in the current state so that a clear
  // request or a PS takeover in the same cycle withdraws it before accept.
  assign o_psum_rdy = (state_r == ST_IDLE) & ~psenb_s & ~i_clr_start & ~rst;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_WIDTH-1:0] idx);
    return ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(idx) << BYTE_SHIFT);
  endfunction

  // Stored word (arriving on mem_odat in the last WAIT cycle) plus captured data.
  psum_sat_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .SATURATE   (SATURATE)
  ) u_sat_add (
    .a   (mem_odat),
    .b   (data_r),
    .sum (sum_s)
  );

  // Next-state and next-output logic; bus outputs are registered so the
  // values computed here appear on the port in the cycle of the new state.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    data_s    = data_r;
    wait_s    = wait_r;
    addr_s    = mem_addr;
    idat_s    = mem_idat;
    enb_s     = 1'b0;
    wr_s      = 1'b0;
    done_s    = 1'b0;
    err_s     = o_err;
    cnt_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (psenb_s) begin
          state_s = ST_IDLE;
        end else if (i_clr_start) begin
          state_s = ST_CLR;
          idx_s   = '0;
          addr_s  = word_addr('0);
          idat_s  = '0;
          enb_s   = 1'b1;
          wr_s    = 1'b1;
        end else if (i_psum_vld) begin
          idx_s  = i_psum_idx;
          data_s = i_psum_data;
          addr_s = word_addr(i_psum_idx);
          enb_s  = 1'b1;
          if (i_psum_first) begin
            state_s = ST_WR;
            wr_s    = 1'b1;
            idat_s  = i_psum_data;
          end else begin
            state_s = ST_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (psenb_s) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else begin
          // Stay in WAIT for RD_LAT cycles: counter runs RD_LAT-1 down to 0.
          state_s = ST_WAIT;
          wait_s  = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (psenb_s) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else if (wait_r == '0) begin
          state_s = ST_WR;
          idat_s  = sum_s;
          enb_s   = 1'b1;
          wr_s    = 1'b1;
        end else begin
          wait_s = wait_r - WAIT_ONE;
        end
      end
      ST_WR: begin
        if (psenb_s) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else begin
          state_s   = ST_IDLE;
          cnt_inc_s = 1'b1;
        end
      end
      ST_CLR: begin
        if (psenb_s) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else if (idx_r == LAST_IDX) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          idx_s  = idx_r + IDX_ONE;
          addr_s = word_addr(idx_r + IDX_ONE);
          idat_s = '0;
          enb_s  = 1'b1;
          wr_s   = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, captured operands, counters and registered port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      data_r     <= '0;
      wait_r     <= '0;
      mem_addr   <= '0;
      mem_idat   <= '0;
      mem_wren   <= '0;
      mem_enb    <= 1'b0;
      o_clr_done <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
      o_wr_cnt   <= 32'd0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      data_r     <= data_s;
      wait_r     <= wait_s;
      mem_addr   <= addr_s;
      mem_idat   <= idat_s;
      mem_wren   <= wr_s ? {NUM_BYTE{1'b1}} : {NUM_BYTE{1'b0}};
      mem_enb    <= enb_s;
      o_clr_done <= done_s;
      o_busy     <= (state_s != ST_IDLE);
      o_err      <= err_s;
      if (cnt_inc_s) begin
        o_wr_cnt <= o_wr_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Self-checking bench for psum_accum_ctrl (DEPTH=8, RD_LAT=2, SATURATE=1).
// A small BRAM model answers the DUT's port; expected values come from a
// word-level reference array updated with plain saturating arithmetic.
module tb_psum_accum_ctrl;

  localparam int DW = 32, AW = 32, NB = 4, RW = 32, IW = 10;
  localparam int DEPTH = 8, RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] conf = '0;
  logic          vld = 1'b0;
  logic [IW-1:0] idx = '0;
  logic [DW-1:0] data = '0;
  logic          first = 1'b0;
  logic          clr_start = 1'b0;
  logic          o_psum_rdy, o_clr_done, o_busy, o_err;
  logic [31:0]   o_wr_cnt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_idat;
  logic [DW-1:0] mem_odat;
  logic [NB-1:0] mem_wren;
  logic          mem_enb, mem_rst;

  int          checks = 0;
  int          failures = 0;
  int unsigned exp_cnt = 0;
  logic [31:0] ref_mem [0:15];
  logic [31:0] bram [0:15];
  logic [31:0] rd_p1;

  psum_accum_ctrl #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_BYTE (NB), .REG_WIDTH (RW),
    .IDX_WIDTH (IW), .DEPTH (DEPTH), .BASE_ADDR (32'h0), .RD_LAT (RD_LAT),
    .SATURATE (1)
  ) dut (
    .clk (clk), .rst (rst), .i_conf_ctrl (conf),
    .i_psum_vld (vld), .i_psum_idx (idx), .i_psum_data (data),
    .i_psum_first (first), .o_psum_rdy (o_psum_rdy),
    .i_clr_start (clr_start), .o_clr_done (o_clr_done),
    .o_busy (o_busy), .o_err (o_err), .o_wr_cnt (o_wr_cnt),
    .mem_addr (mem_addr), .mem_idat (mem_idat), .mem_odat (mem_odat),
    .mem_wren (mem_wren), .mem_enb (mem_enb), .mem_rst (mem_rst)
  );

  always #5 clk = ~clk;

  // BRAM model: 2-cycle read latency, ignores the PL port while the PS owns it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bram[i] <= 32'h0;
      rd_p1    <= 32'h0;
      mem_odat <= 32'h0;
    end else begin
      if (mem_enb && !conf[2]) begin
        if (mem_wren == 4'hF) bram[mem_addr[5:2]] <= mem_idat;
        else rd_p1 <= bram[mem_addr[5:2]];
      end
      mem_odat <= rd_p1;
    end
  end

  function automatic logic [31:0] sat_ref(input logic [31:0] s, input logic [31:0] d);
    longint t;
    t = longint'($signed(s)) + longint'($signed(d));
    if (t > 64'sd2147483647) return 32'h7FFFFFFF;
    if (t < -64'sd2147483648) return 32'h80000000;
    return 32'(t);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input logic [3:0] i, input logic [31:0] e);
    chk("wr_enb", mem_enb, 1);
    chk("wr_wren", mem_wren, 4'hF);
    chk("wr_addr", mem_addr, {i, 2'b00});
    chk("wr_idat", mem_idat, e);
    chk("wr_rdy", o_psum_rdy, 0);
    chk("wr_busy", o_busy, 1);
  endtask

  // One partial-sum transaction starting in an idle cycle.
  task automatic psum_op(input logic [3:0] i, input logic [31:0] d, input logic f);
    logic [31:0] e;
    e = f ? d : sat_ref(ref_mem[i], d);
    idx = IW'(i); data = d; first = f; vld = 1'b1;
    #1;
    chk("rdy_idle", o_psum_rdy, 1);
    step();
    vld = 1'b0; idx = IW'($urandom); data = $urandom; first = ~f;
    if (f) begin
      chk_wr(i, e);
    end else begin
      chk("rd_enb", mem_enb, 1);
      chk("rd_wren", mem_wren, 0);
      chk("rd_addr", mem_addr, {i, 2'b00});
      chk("rd_rdy", o_psum_rdy, 0);
      for (int k = 0; k < RD_LAT; k++) begin
        step();
        chk("wait_enb", mem_enb, 0);
        chk("wait_rdy", o_psum_rdy, 0);
      end
      step();
      chk_wr(i, e);
    end
    step();
    exp_cnt++;
    ref_mem[i] = e;
    chk("wr_cnt", o_wr_cnt, exp_cnt);
    chk("idle_busy", o_busy, 0);
  endtask

  task automatic random_ops(input int n);
    logic [3:0]  ri;
    logic [31:0] rd;
    for (int k = 0; k < n; k++) begin
      ri = 4'($urandom_range(0, 15));
      rd = $urandom;
      psum_op(ri, rd, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, o_psum_rdy, 0);
    chk({tag, "_done"}, o_clr_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_cnt"}, o_wr_cnt, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_idat"}, mem_idat, 0);
    chk({tag, "_wren"}, mem_wren, 0);
    chk({tag, "_enb"}, mem_enb, 0);
    chk({tag, "_mrst"}, mem_rst, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (3) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();
    chk("post_reset_rdy", o_psum_rdy, 1);

    // T1 overwrite, T2 accumulate
    psum_op(4'd5, 32'h10, 1'b1);
    psum_op(4'd5, 32'h20, 1'b0);
    // T3 saturation at both ends
    psum_op(4'd6, 32'h7FFFFFF0, 1'b1);
    psum_op(4'd6, 32'h20, 1'b0);
    psum_op(4'd7, 32'h80000000, 1'b1);
    psum_op(4'd7, 32'hFFFFFFFF, 1'b0);
    random_ops(16);

    // T4 clear sweep; clr_start wins over a simultaneous psum
    clr_start = 1'b1; vld = 1'b1; idx = IW'(12); first = 1'b1;
    #1;
    chk("clr_prio_rdy", o_psum_rdy, 0);
    step();
    clr_start = 1'b0; vld = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      chk("clr_enb", mem_enb, 1);
      chk("clr_wren", mem_wren, 4'hF);
      chk("clr_addr", mem_addr, 32'(k * 4));
      chk("clr_idat", mem_idat, 0);
      chk("clr_done_early", o_clr_done, 0);
      step();
    end
    chk("clr_done", o_clr_done, 1);
    chk("clr_end_enb", mem_enb, 0);
    step();
    chk("clr_done_pulse", o_clr_done, 0);
    chk("clr_cnt", o_wr_cnt, exp_cnt);
    chk("clr_busy", o_busy, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    psum_op(4'd2, 32'h5, 1'b0);

    // T5 PS takes the bus during WAIT
    idx = IW'(9); data = 32'h1234; first = 1'b0; vld = 1'b1;
    step();
    vld = 1'b0;
    chk("t5_rd_enb", mem_enb, 1);
    step();
    conf = 32'h4;
    step();
    chk("t5_abort_busy", o_busy, 0);
    chk("t5_abort_enb", mem_enb, 0);
    chk("t5_err", o_err, 1);
    chk("t5_rdy_psenb", o_psum_rdy, 0);
    vld = 1'b1; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_hold_busy", o_busy, 0);
      chk("t5_hold_enb", mem_enb, 0);
      chk("t5_hold_rdy", o_psum_rdy, 0);
      step();
    end
    vld = 1'b0; conf = 32'h0;
    #1;
    chk("t5_recover_rdy", o_psum_rdy, 1);
    step();
    chk("t5_cnt", o_wr_cnt, exp_cnt);
    chk("t5_err_sticky", o_err, 1);
    psum_op(4'd9, 32'h3, 1'b0);

    // T6 reset in the middle of a clear
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (3) step();
    chk("t6_idx3_addr", mem_addr, 32'h0C);
    rst = 1'b1;
    step();
    chk_reset_outputs("t6");
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t6_no_done", o_clr_done, 0);
      chk("t6_no_enb", mem_enb, 0);
    end
    random_ops(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
